operand_capture: RTL and testbench
==================================

// Module: operand_capture
// PURPOSE
//  Downstream of the keypad output-control FSM. Assembles decimal keypad digits into the
//  binary operands A and B while the FSM's enable for that operand is high. On the FSM's
//  ready pulse it launches the Booth multiplier with a valid/ready handshake, then holds
//  the operands stable until the multiplier reports done.
// PARAMETERS
//  OPERAND_W   8  width of each captured operand (unsigned binary)
//  MAX_DIGITS  2  decimal digits accepted per operand; further digits are ignored
// PORTS
//  clk          in   1          system clock; single clock domain
//  rst          in   1          synchronous, active-low reset
//  key_pressed  in   1          keypad strobe; level, edge-detected internally
//  key_code     in   4          keypad code; 0-9 = digit, 10-15 ignored
//  enable_a     in   1          FSM is collecting operand A
//  enable_b     in   1          FSM is collecting operand B
//  ready_in     in   1          FSM one-cycle pulse: both operands entered
//  mult_ready   in   1          multiplier can accept operands
//  mult_done    in   1          multiplier finished (one-cycle pulse)
//  operand_a    out  OPERAND_W  captured A, held stable from launch to done
//  operand_b    out  OPERAND_W  captured B, held stable from launch to done
//  mult_valid   out  1          operands offered to the multiplier
//  busy         out  1          high in LAUNCH and WAIT_DONE
//  overflow     out  1          sticky: a digit would have exceeded 2^OPERAND_W-1
// BEHAVIOUR
//  - Reset (rst==0 at posedge): all outputs 0; state COLLECT; digit counters 0; edge
//    register 0. A reset mid-operation drops mult_valid immediately and abandons the launch.
//  - Key event = key_pressed & ~key_pressed_q. The event is accepted only in COLLECT with
//    key_code<=9.
//  - Accepted digit d, target A if enable_a, else B if enable_b. enable_a wins when both
//    enables are high. Neither enable high -> the event is ignored.
//  - Digit update: if cnt<MAX_DIGITS, then op <= op*10 + d and cnt++.
//    op*10 = (op<<3)+(op<<1), computed in OPERAND_W+4 bits.
//    If the result exceeds 2^OPERAND_W-1: op saturates to all ones and overflow is set.
//    Once cnt==MAX_DIGITS, further digits are ignored (no wrap).
//  - On the first accepted digit with cnt==0, the old operand value is replaced (op<=d),
//    not accumulated.
//  - The operand register updates one cycle after the key edge.
//  - FSM states:
//    COLLECT  : digits accepted. ready_in -> LAUNCH.
//    LAUNCH   : mult_valid=1, busy=1; operands frozen; keys and ready_in ignored.
//               mult_ready -> WAIT_DONE. Transfer happens in a cycle where
//               mult_valid & mult_ready. mult_valid falls the cycle after the transfer.
//    WAIT_DONE: busy=1; keys and ready_in ignored. mult_done -> COLLECT.
//               On that transition cnt_a, cnt_b and overflow clear; operand values are kept.
//  - Simultaneous events:
//    ready_in in the same cycle as an accepted digit: the digit is written and the state
//    moves to LAUNCH together, so the launched operand includes that digit.
//    mult_done arriving in LAUNCH: ignored; only WAIT_DONE consumes mult_done.
//  - Latency: ready_in -> mult_valid high is 1 cycle; mult_done -> COLLECT is 1 cycle.
// STRUCTURE
//  - Shared package booth_pkg holds:
//    typedef enum logic [1:0] {COLLECT, LAUNCH, WAIT_DONE} capture_state_t;
//    localparam KEY_DIGIT_MAX = 4'd9.
//  - Sub-module digit_accumulator (OPERAND_W, MAX_DIGITS), instantiated twice (A and B).
//    Ports: clk, rst, load_digit, digit[3:0], clear_cnt, value, sat.
//    It owns the count, the *10+d arithmetic and saturation.
//  - Top level: edge detect, target arbitration, capture_state_t FSM, overflow OR.
// TESTING
//  1. enable_a, keys 4,2; then enable_b, keys 1,7; ready_in -> operand_a=42, operand_b=17,
//     mult_valid high 1 cycle after ready_in.
//  2. Hold mult_ready=0 for 5 cycles -> mult_valid and operands stay stable; mult_ready=1
//     -> mult_valid low next cycle, busy stays 1 until mult_done.
//  3. enable_a, keys 9,9,5 -> operand_a=99, third digit ignored, overflow=0.
//     OPERAND_W=6 with keys 9,9 -> operand_a=63, overflow=1.
//  4. enable_a and enable_b both high, key 3 -> operand_a=3, operand_b unchanged.
//     key_code 12 -> no change. Held key_pressed for 10 cycles -> one digit only.
//  5. Key 5 while busy -> ignored. After mult_done, enable_a, key 8 -> operand_a=8
//     (fresh entry, not 428).
//  6. rst=0 during LAUNCH -> next cycle mult_valid=0, busy=0, operands 0, state COLLECT.
//     Asynchronous rst pulse between edges -> no effect.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and constants for the keypad-to-Booth-multiplier operand path.
package booth_pkg;

  // Capture controller states: collecting digits, offering operands, waiting for the result.
  typedef enum logic [1:0] {
    COLLECT   = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } capture_state_t;

  // Highest keypad code that represents a decimal digit.
  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

endpackage : booth_pkg

// File: rtl/operand_capture_if.sv
// Bundle of keypad, FSM and multiplier signals around operand_capture.
//
// Handshake: the multiplier transfer happens in every cycle where mult_valid and
// mult_ready are both high. mult_valid stays high, with operand_a/operand_b frozen,
// until that cycle, and falls in the cycle after it.
// mult_valid never depends combinationally on mult_ready.
interface operand_capture_if #(
  parameter int OPERAND_W = 8
);
  import booth_pkg::*;

  logic                 key_pressed;
  logic [3:0]           key_code;
  logic                 enable_a;
  logic                 enable_b;
  logic                 ready_in;
  logic                 mult_ready;
  logic                 mult_done;
  logic [OPERAND_W-1:0] operand_a;
  logic [OPERAND_W-1:0] operand_b;
  logic                 mult_valid;
  logic                 busy;
  logic                 overflow;
  capture_state_t       state;      // debug view of the capture FSM

  // Keypad/FSM/multiplier side: drives the inputs, observes the operands.
  modport master (
    output key_pressed, key_code, enable_a, enable_b, ready_in, mult_ready, mult_done,
    input  operand_a, operand_b, mult_valid, busy, overflow, state
  );

  // operand_capture side.
  modport slave (
    input  key_pressed, key_code, enable_a, enable_b, ready_in, mult_ready, mult_done,
    output operand_a, operand_b, mult_valid, busy, overflow, state
  );

endinterface : operand_capture_if

// File: rtl/operand_capture_digit_accumulator.sv
// Builds one unsigned operand from decimal digits: value = value*10 + digit,
// limited to MAX_DIGITS digits and saturating at all ones.
module digit_accumulator #(
  parameter int OPERAND_W  = 8,
  parameter int MAX_DIGITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_digit,
  input  logic [3:0]           digit,
  input  logic                 clear_cnt,
  output logic [OPERAND_W-1:0] value,
  output logic                 sat
);

  localparam int                 CNT_W   = $clog2(MAX_DIGITS + 1);
  localparam int                 EXT_W   = OPERAND_W + 4;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAX_DIGITS);
  localparam logic [EXT_W-1:0]   VAL_MAX = {4'b0000, {OPERAND_W{1'b1}}};

  logic [CNT_W-1:0] cnt;
  logic [EXT_W-1:0] value_ext;
  logic [EXT_W-1:0] base_ext;
  logic [EXT_W-1:0] next_ext;
  logic             next_ovf;

  // Next operand value: the first digit replaces the old value, later ones accumulate.
  always_comb begin
    value_ext = {4'b0000, value};
    base_ext  = '0;
    if (cnt != '0) begin
      base_ext = (value_ext << 3) + (value_ext << 1);
    end
    next_ext = base_ext + {{OPERAND_W{1'b0}}, digit};
    next_ovf = (next_ext > VAL_MAX);
  end

  // Digit count, operand register and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      value <= '0;
      sat   <= 1'b0;
    end else if (clear_cnt) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (load_digit && (cnt < CNT_MAX)) begin
      cnt <= cnt + 1'b1;
      if (next_ovf) begin
        value <= {OPERAND_W{1'b1}};
        sat   <= 1'b1;
      end else begin
        value <= next_ext[OPERAND_W-1:0];
      end
    end
  end

endmodule : digit_accumulator

// File: rtl/operand_capture.sv
// Captures keypad digits into operands A and B and hands them to the Booth
// multiplier, holding them stable from launch until the multiplier is done.
module operand_capture
  import booth_pkg::*;
#(
  parameter int OPERAND_W  = 8,
  parameter int MAX_DIGITS = 2
) (
  input logic               clk,
  input logic               rst,
  operand_capture_if.slave  cif
);

  capture_state_t       state;
  capture_state_t       state_nxt;
  logic                 key_q;
  logic                 key_evt;
  logic                 digit_ok;
  logic                 load_a;
  logic                 load_b;
  logic                 clear_cnt;
  logic                 sat_a;
  logic                 sat_b;
  logic [OPERAND_W-1:0] val_a;
  logic [OPERAND_W-1:0] val_b;

  // Previous key level so a held key yields exactly one event.
  always_ff @(posedge clk) begin
    if (!rst) begin
      key_q <= 1'b0;
    end else begin
      key_q <= cif.key_pressed;
    end
  end

  // Digit acceptance and target selection; A has priority when both enables are high.
  always_comb begin
    key_evt  = cif.key_pressed & ~key_q;
    digit_ok = key_evt && (state == COLLECT) && (cif.key_code <= KEY_DIGIT_MAX);
    load_a   = digit_ok && cif.enable_a;
    load_b   = digit_ok && !cif.enable_a && cif.enable_b;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-state outputs; done is only consumed in WAIT_DONE.
  always_comb begin
    state_nxt      = state;
    clear_cnt      = 1'b0;
    cif.mult_valid = 1'b0;
    cif.busy       = 1'b0;
    case (state)
      COLLECT: begin
        if (cif.ready_in) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        cif.mult_valid = 1'b1;
        cif.busy       = 1'b1;
        if (cif.mult_ready) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        cif.busy = 1'b1;
        if (cif.mult_done) begin
          state_nxt = COLLECT;
          clear_cnt = 1'b1;
        end
      end
      default: begin
        state_nxt = COLLECT;
      end
    endcase
  end

  digit_accumulator #(
    .OPERAND_W  (OPERAND_W),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_acc_a (
    .clk        (clk),
    .rst        (rst),
    .load_digit (load_a),
    .digit      (cif.key_code),
    .clear_cnt  (clear_cnt),
    .value      (val_a),
    .sat        (sat_a)
  );

  digit_accumulator #(
    .OPERAND_W  (OPERAND_W),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_acc_b (
    .clk        (clk),
    .rst        (rst),
    .load_digit (load_b),
    .digit      (cif.key_code),
    .clear_cnt  (clear_cnt),
    .value      (val_b),
    .sat        (sat_b)
  );

  // Operands, combined overflow and debug state to the interface.
  always_comb begin
    cif.operand_a = val_a;
    cif.operand_b = val_b;
    cif.overflow  = sat_a | sat_b;
    cif.state     = state;
  end

endmodule : operand_capture

// File: tb/tb_operand_capture.sv
// Directed bench for operand_capture: an 8-bit instance for the main flow and a
// 6-bit instance for saturation. Launches are checked by a scoreboard monitor.
module tb_operand_capture;
  import booth_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  operand_capture_if #(.OPERAND_W(8)) vif  ();
  operand_capture_if #(.OPERAND_W(6)) vif6 ();

  operand_capture #(.OPERAND_W(8), .MAX_DIGITS(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .cif (vif.slave)
  );

  operand_capture #(.OPERAND_W(6), .MAX_DIGITS(2)) u_dut6 (
    .clk (clk),
    .rst (rst),
    .cif (vif6.slave)
  );

  int n_cmp;
  int n_err;

  // Expected {operand_a, operand_b} for each multiplier transfer, in order.
  logic [15:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] code);
    vif.key_code    = code;
    vif.key_pressed = 1'b1;
    tick();
    vif.key_pressed = 1'b0;
    tick();
  endtask

  task automatic press6(input logic [3:0] code);
    vif6.key_code    = code;
    vif6.key_pressed = 1'b1;
    tick();
    vif6.key_pressed = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic pulse_ready();
    vif.ready_in = 1'b1;
    tick();
    vif.ready_in = 1'b0;
  endtask

  task automatic pulse_done();
    vif.mult_done = 1'b1;
    tick();
    vif.mult_done = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst && vif.mult_valid && vif.mult_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL launch_unexpected: got a=%0d b=%0d expected no transfer",
                 vif.operand_a, vif.operand_b);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({vif.operand_a, vif.operand_b} !== e) begin
          n_err++;
          $display("FAIL launch: got a=%0d b=%0d expected a=%0d b=%0d",
                   vif.operand_a, vif.operand_b, e[15:8], e[7:0]);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    vif.key_pressed = 0; vif.key_code = 0; vif.enable_a = 0; vif.enable_b = 0;
    vif.ready_in = 0; vif.mult_ready = 0; vif.mult_done = 0;
    vif6.key_pressed = 0; vif6.key_code = 0; vif6.enable_a = 0; vif6.enable_b = 0;
    vif6.ready_in = 0; vif6.mult_ready = 0; vif6.mult_done = 0;
    tick();
    do_reset();

    // Reset state
    chk("rst_a", vif.operand_a, 0);
    chk("rst_b", vif.operand_b, 0);
    chk("rst_valid", vif.mult_valid, 0);
    chk("rst_busy", vif.busy, 0);
    chk("rst_ovf", vif.overflow, 0);
    chk("rst_state", vif.state, COLLECT);

    // 1: A=42, B=17, launch
    vif.enable_a = 1;
    press(4);
    chk("a_first_digit", vif.operand_a, 4);
    press(2);
    chk("a_42", vif.operand_a, 42);
    vif.enable_a = 0;
    vif.enable_b = 1;
    press(1);
    press(7);
    vif.enable_b = 0;
    chk("b_17", vif.operand_b, 17);
    exp_q.push_back({8'd42, 8'd17});
    pulse_ready();
    chk("launch_valid", vif.mult_valid, 1);
    chk("launch_busy", vif.busy, 1);

    // 2: stall with mult_ready=0; done in LAUNCH ignored; keys ignored
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", vif.mult_valid, 1);
      chk("stall_ab", {vif.operand_a, vif.operand_b}, {8'd42, 8'd17});
    end
    pulse_done();
    chk("done_in_launch_state", vif.state, LAUNCH);
    vif.enable_a = 1;
    press(5);
    vif.enable_a = 0;
    chk("key_in_launch_a", vif.operand_a, 42);
    vif.mult_ready = 1;
    tick();
    vif.mult_ready = 0;
    chk("after_xfer_valid", vif.mult_valid, 0);
    chk("after_xfer_busy", vif.busy, 1);
    chk("after_xfer_state", vif.state, WAIT_DONE);

    // 5: keys and ready_in ignored while waiting; fresh entry after done
    vif.enable_a = 1;
    press(5);
    vif.enable_a = 0;
    chk("key_in_wait_a", vif.operand_a, 42);
    pulse_ready();
    tick();
    chk("ready_in_wait_state", vif.state, WAIT_DONE);
    pulse_done();
    chk("done_state", vif.state, COLLECT);
    chk("done_busy", vif.busy, 0);
    chk("done_keeps_a", vif.operand_a, 42);
    vif.enable_a = 1;
    press(8);
    vif.enable_a = 0;
    chk("fresh_a_8", vif.operand_a, 8);
    chk("fresh_b_kept", vif.operand_b, 17);

    // 3: third digit ignored, no overflow at 99
    do_reset();
    vif.enable_a = 1;
    press(9);
    press(9);
    chk("a_99", vif.operand_a, 99);
    press(5);
    vif.enable_a = 0;
    chk("a_third_ignored", vif.operand_a, 99);
    chk("a_99_no_ovf", vif.overflow, 0);

    // 4: priority, non-digit codes, held key
    do_reset();
    vif.enable_b = 1;
    press(6);
    chk("b_6", vif.operand_b, 6);
    vif.enable_a = 1;
    vif.key_code = 3;
    vif.key_pressed = 1;
    for (int i = 0; i < 10; i++) tick();
    vif.key_pressed = 0;
    tick();
    chk("both_en_a_held", vif.operand_a, 3);
    chk("both_en_b_unchanged", vif.operand_b, 6);
    press(12);
    chk("code12_a", vif.operand_a, 3);
    chk("code12_b", vif.operand_b, 6);

    // Digit and ready_in in the same cycle: launched A includes the digit
    vif.enable_b = 0;
    exp_q.push_back({8'd37, 8'd6});
    vif.key_code = 7;
    vif.key_pressed = 1;
    vif.ready_in = 1;
    tick();
    vif.key_pressed = 0;
    vif.ready_in = 0;
    vif.enable_a = 0;
    chk("same_cycle_a", vif.operand_a, 37);
    chk("same_cycle_valid", vif.mult_valid, 1);
    vif.mult_ready = 1;
    tick();
    vif.mult_ready = 0;
    pulse_done();
    chk("same_cycle_back", vif.state, COLLECT);

    // 6: asynchronous glitch on rst has no effect; sampled reset in LAUNCH aborts
    pulse_ready();
    chk("relaunch_valid", vif.mult_valid, 1);
    rst = 0;
    #2;
    rst = 1;
    tick();
    chk("glitch_valid", vif.mult_valid, 1);
    chk("glitch_a", vif.operand_a, 37);
    rst = 0;
    tick();
    chk("abort_valid", vif.mult_valid, 0);
    chk("abort_busy", vif.busy, 0);
    chk("abort_a", vif.operand_a, 0);
    chk("abort_b", vif.operand_b, 0);
    chk("abort_state", vif.state, COLLECT);
    rst = 1;
    tick();

    // 3b: 6-bit operand saturates at 63; overflow clears on done, value kept
    vif6.enable_a = 1;
    press6(9);
    chk("w6_a_9", vif6.operand_a, 9);
    chk("w6_ovf_0", vif6.overflow, 0);
    press6(9);
    vif6.enable_a = 0;
    chk("w6_a_sat", vif6.operand_a, 63);
    chk("w6_ovf_1", vif6.overflow, 1);
    vif6.ready_in = 1;
    tick();
    vif6.ready_in = 0;
    vif6.mult_ready = 1;
    tick();
    vif6.mult_ready = 0;
    vif6.mult_done = 1;
    tick();
    vif6.mult_done = 0;
    chk("w6_ovf_cleared", vif6.overflow, 0);
    chk("w6_a_kept", vif6.operand_a, 63);

    tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_operand_capture
